// File: rtl/ucode_pkg.sv
// ----------------------------------------------------------------------------
// ucode_pkg
//   Shared definitions for the microcode sequencer: opcode values, the
//   sequencer state encoding, strobe bit positions and the decoded control
//   vector passed from ucode_decode to ucode_seq.
//   No ports (package).
// ----------------------------------------------------------------------------
package ucode_pkg;

    // Opcodes, instr[7:4]. Values 9..E are undefined.
    localparam logic [3:0] OPC_NOP  = 4'h0;
    localparam logic [3:0] OPC_LDI  = 4'h1;
    localparam logic [3:0] OPC_LDA  = 4'h2;
    localparam logic [3:0] OPC_LDB  = 4'h3;
    localparam logic [3:0] OPC_ADD  = 4'h4;
    localparam logic [3:0] OPC_OUTA = 4'h5;
    localparam logic [3:0] OPC_OUTB = 4'h6;
    localparam logic [3:0] OPC_CLR  = 4'h7;
    localparam logic [3:0] OPC_JMP  = 4'h8;
    localparam logic [3:0] OPC_HLT  = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    // Register load strobes: rs[0] is rs1 (A) ... rs[4] is rs5 (OP).
    localparam int RS_A   = 0;
    localparam int RS_B   = 1;
    localparam int RS_ALU = 2;
    localparam int RS_OUT = 3;
    localparam int RS_OP  = 4;
    localparam int RS_N   = 5;

    // Bus-write strobes: ws[0] is ws1 (A), ws[1] ws2 (B), ws[2] ws3 (OP).
    localparam int WS_A  = 0;
    localparam int WS_B  = 1;
    localparam int WS_OP = 2;
    localparam int WS_N  = 3;

    // Decoded control for one instruction.
    typedef struct packed {
        logic [RS_N-1:0] rs;
        logic [WS_N-1:0] ws;
        logic            lrst;
        logic            jmp;
        logic            hlt;
        logic            ill;
    } dec_t;

endpackage

// File: rtl/ucode_decode.sv
// ----------------------------------------------------------------------------
// ucode_decode
//   Combinational opcode decoder. Maps an opcode onto the register-load and
//   bus-write strobes plus the jump / halt / illegal control bits. Each opcode
//   enables at most one bus-write strobe.
//   Optional feature macro: ILLEGAL_OP_TRAP_EN -- when defined, undefined
//   opcodes raise the ill bit; otherwise they decode as NOP.
// Ports
//   i_opcode  in   OPC_W  instruction opcode field
//   o_dec     out  dec_t  decoded control vector
// ----------------------------------------------------------------------------
module ucode_decode
    import ucode_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic [OPC_W-1:0] i_opcode,
    output dec_t             o_dec
);

    always_comb begin
        // NOTE: every field gets a default before the case, so no path leaves
        // a bit unassigned and no latch is inferred.
        o_dec = '0;
        case (i_opcode)
            OPC_NOP: ;
            OPC_LDI: o_dec.rs[RS_OP] = 1'b1;
            OPC_LDA: begin
                o_dec.ws[WS_OP] = 1'b1;
                o_dec.rs[RS_A]  = 1'b1;
            end
            OPC_LDB: begin
                o_dec.ws[WS_OP] = 1'b1;
                o_dec.rs[RS_B]  = 1'b1;
            end
            OPC_ADD: o_dec.rs[RS_ALU] = 1'b1;
            OPC_OUTA: begin
                o_dec.ws[WS_A]   = 1'b1;
                o_dec.rs[RS_OUT] = 1'b1;
            end
            OPC_OUTB: begin
                o_dec.ws[WS_B]   = 1'b1;
                o_dec.rs[RS_OUT] = 1'b1;
            end
            OPC_CLR: o_dec.lrst = 1'b1;
            OPC_JMP: o_dec.jmp  = 1'b1;
            OPC_HLT: o_dec.hlt  = 1'b1;
            default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                o_dec.ill = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/ucode_seq.sv
// ----------------------------------------------------------------------------
// ucode_seq
//   Microcode sequencer. Runs a fixed FETCH / DECODE / EXEC loop per 8-bit
//   instruction: FETCH latches the ROM word and advances pc, DECODE registers
//   the immediate, EXEC presents the decoded strobes for exactly one cycle.
//   HLT (and, with the trap enabled, an undefined opcode) parks the sequencer
//   in HALT until grst.
//   Optional feature macro: ILLEGAL_OP_TRAP_EN -- enables the sticky illegal
//   flag and halting on undefined opcodes; otherwise illegal is tied 0.
// Ports
//   clk      in   1            system clock, rising edge
//   grst     in   1            synchronous active-high reset
//   run      in   1            1 = advance, 0 = hold at next FETCH
//   instr    in   OPC_W+IMM_W  program ROM data at address pc
//   pc       out  PC_W         program counter / ROM address
//   imm      out  IMM_W        registered immediate field
//   rs       out  5            register load strobes (rs1..rs5)
//   ws       out  3            bus-write strobes (ws1..ws3)
//   lrst     out  1            one-cycle local clear
//   halt     out  1            sticky halted flag
//   illegal  out  1            sticky illegal-opcode flag
// ----------------------------------------------------------------------------
module ucode_seq
    import ucode_pkg::*;
#(
    parameter int PC_W  = 4,
    parameter int OPC_W = 4,
    parameter int IMM_W = 4
) (
    input  logic                   clk,
    input  logic                   grst,
    input  logic                   run,
    input  logic [OPC_W+IMM_W-1:0] instr,
    output logic [PC_W-1:0]        pc,
    output logic [IMM_W-1:0]       imm,
    output logic [RS_N-1:0]        rs,
    output logic [WS_N-1:0]        ws,
    output logic                   lrst,
    output logic                   halt,
    output logic                   illegal
);

    state_t                   r_state;
    logic [PC_W-1:0]          r_pc;
    logic [OPC_W+IMM_W-1:0]   r_ir;
    logic [IMM_W-1:0]         r_imm;
    logic [RS_N-1:0]          r_rs;
    logic [WS_N-1:0]          r_ws;
    logic                     r_lrst;
    logic                     r_jmp;
    logic                     r_hlt;
    logic                     r_ill;
    logic                     r_halt;

    logic [OPC_W-1:0]         w_opcode;
    dec_t                     w_dec;

    assign w_opcode = r_ir[OPC_W+IMM_W-1 -: OPC_W];

    ucode_decode #(
        .OPC_W (OPC_W)
    ) u_decode (
        .i_opcode (w_opcode),
        .o_dec    (w_dec)
    );

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (grst) begin
            r_state <= ST_FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
            r_imm   <= '0;
            r_rs    <= '0;
            r_ws    <= '0;
            r_lrst  <= 1'b0;
            r_jmp   <= 1'b0;
            r_hlt   <= 1'b0;
            r_ill   <= 1'b0;
            r_halt  <= 1'b0;
        end else begin
            // Strobes drop by default so they are high only in the EXEC cycle.
            r_rs   <= '0;
            r_ws   <= '0;
            r_lrst <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    if (run) begin
                        r_ir    <= instr;
                        r_pc    <= r_pc + PC_W'(1);
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    // Strobes are registered here so they appear during EXEC.
                    r_imm   <= r_ir[IMM_W-1:0];
                    r_rs    <= w_dec.rs;
                    r_ws    <= w_dec.ws;
                    r_lrst  <= w_dec.lrst;
                    r_jmp   <= w_dec.jmp;
                    r_hlt   <= w_dec.hlt;
                    r_ill   <= w_dec.ill;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (r_hlt || r_ill) begin
                        r_halt  <= 1'b1;
                        r_state <= ST_HALT;
                    end else begin
                        // A jump overrides the increment done in FETCH.
                        if (r_jmp) begin
                            r_pc <= PC_W'(r_imm);
                        end
                        r_state <= ST_FETCH;
                    end
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_FETCH;
            endcase
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clk) begin
        if (grst) begin
            r_illegal <= 1'b0;
        end else if (r_state == ST_EXEC && r_ill) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    assign pc   = r_pc;
    assign imm  = r_imm;
    assign rs   = r_rs;
    assign ws   = r_ws;
    assign lrst = r_lrst;
    assign halt = r_halt;

endmodule
